reg_sync_arbiter: RTL and testbench

REG_SYNC_ARBITER -- requirements
Module: reg_sync_arbiter

---
 rtl/reg_sync_arbiter_if.sv | 31 +++
 rtl/reg_sync_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_sync_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_sync_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, the arbiter and one register synchronizer.
// Latency: none (wires only).
// Backpressure: req_busy tells each requester to hold off. Sync side is pulse/ack.
interface reg_sync_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int SELW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_en;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_busy;
    logic [NUM_REQ-1:0]       req_done;
    logic [NUM_REQ-1:0]       req_err;
    logic                     sync_en;
    logic [WIDTH-1:0]         sync_data;
    logic [SELW-1:0]          sync_sel;
    logic                     sync_ack;

    // Environment view: requesters plus the synchronizer's ack.
    modport master (
        output req_en, req_data, sync_ack,
        input  req_busy, req_done, req_err, sync_en, sync_data, sync_sel
    );

    // Arbiter view.
    modport slave (
        input  req_en, req_data, sync_ack,
        output req_busy, req_done, req_err, sync_en, sync_data, sync_sel
    );
endinterface

// File: rtl/reg_sync_arbiter.sv
// Round-robin arbiter that shares one register synchronizer among NUM_REQ requesters.
// Latency: req_en -> sync_en is 2 cycles when idle. sync_ack -> req_done is 1 cycle.
// Backpressure: req_busy holds a requester off. REG_SYNC_ARB_TIMEOUT_EN adds a WAIT timeout (req_err).
module reg_sync_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_sync_arbiter_if.slave   bus
);
    localparam int SELW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [WIDTH-1:0]   hold_q [NUM_REQ];
    logic [SELW-1:0]    last_q, last_d;
    logic [WIDTH-1:0]   data_q;
    logic [SELW-1:0]    sel_q;
    logic               en_q;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] accept;
    logic               grant_vld;
    logic [SELW-1:0]    grant_idx;
    logic               load;

    // A request is taken only when the slot is free. The cycle carrying that slot's
    // done pulse also counts as occupied, so a requester must re-request after done.
    assign accept = bus.req_en & ~pending_q & ~done_q;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        logic [SELW:0] sum;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_q} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(NUM_REQ)) begin
                sum = sum - (SELW+1)'(NUM_REQ);
            end
            if (!grant_vld && pending_q[sum[SELW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[SELW-1:0];
            end
        end
    end

`ifdef REG_SYNC_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0]    cnt_q;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               timed_out;

    // The transfer is abandoned on the cycle the counter would reach TIMEOUT.
    assign timed_out = (cnt_q == CNTW'(TIMEOUT - 1));

    // WAIT cycle counter: cleared as WAIT is entered, advanced while no ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && !bus.sync_ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.req_err = err_q;
`else
    assign bus.req_err = '0;
`endif

    // Next-state logic for the IDLE/ISSUE/WAIT controller and the pending set.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | accept;
        done_d    = '0;
        last_d    = last_q;
        load      = 1'b0;
`ifdef REG_SYNC_ARB_TIMEOUT_EN
        err_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_ISSUE;
                    last_d  = grant_idx;
                    load    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sync_ack) begin
                    done_d[last_q]    = 1'b1;
                    pending_d[last_q] = 1'b0;
                    state_d           = ST_IDLE;
                end
`ifdef REG_SYNC_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    err_d[last_q]     = 1'b1;
                    pending_d[last_q] = 1'b0;
                    state_d           = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, grant pointer and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            last_q    <= SELW'(NUM_REQ - 1);
            done_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            done_q    <= done_d;
            en_q      <= (state_d == ST_ISSUE);
        end
    end

    // Per-requester capture of data on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    hold_q[i] <= bus.req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Synchronizer data/select: loaded only at grant, so they stay frozen through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (load) begin
            data_q <= hold_q[grant_idx];
            sel_q  <= grant_idx;
        end
    end

    assign bus.req_busy  = pending_q;
    assign bus.req_done  = done_q;
    assign bus.sync_en   = en_q;
    assign bus.sync_data = data_q;
    assign bus.sync_sel  = sel_q;
endmodule

// File: tb/tb_reg_sync_arbiter.sv
module tb_reg_sync_arbiter;
    localparam int NR = 4;
    localparam int W  = 16;
`ifdef REG_SYNC_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    reg_sync_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    assign bus.sync_ack = ack_auto | ack_man;

    reg_sync_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           sel;
        logic [W-1:0] data;
    } xfer_t;

    xfer_t exp_grant[$];
    int    exp_done[$];
    int    exp_err[$];
    int    en_hist[$];

    int checks = 0;
    int failures = 0;
    int en_count = 0, done_count = 0, err_count = 0;
    int last_en_cyc = 0, last_done_cyc = 0, last_done_idx = 0, last_err_cyc = 0;
    int ack_dly = 0;
    logic [W-1:0] last_data = '0;
    int    last_sel = 0;
    xfer_t mon_e;

    function automatic int first_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard: compares every DUT output event against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
            last_sel  = 0;
        end else begin
            if (bus.sync_en) begin
                checks++;
                en_count++;
                last_en_cyc = cyc;
                en_hist.push_back(cyc);
                if (exp_grant.size() == 0) begin
                    failures++;
                    $display("FAIL grant: unexpected sync_en sel=%0d data=%h, required none", bus.sync_sel, bus.sync_data);
                end else begin
                    mon_e = exp_grant.pop_front();
                    if (int'(bus.sync_sel) != mon_e.sel || bus.sync_data !== mon_e.data) begin
                        failures++;
                        $display("FAIL grant: got sel=%0d data=%h, required sel=%0d data=%h", bus.sync_sel, bus.sync_data, mon_e.sel, mon_e.data);
                    end
                end
                last_data = bus.sync_data;
                last_sel  = int'(bus.sync_sel);
            end else begin
                checks++;
                if (bus.sync_data !== last_data || int'(bus.sync_sel) != last_sel) begin
                    failures++;
                    $display("FAIL hold: got sel=%0d data=%h, required sel=%0d data=%h", bus.sync_sel, bus.sync_data, last_sel, last_data);
                end
            end
            if (bus.req_done != '0) begin
                checks++;
                done_count++;
                last_done_cyc = cyc;
                last_done_idx = first_idx(bus.req_done);
                if (!$onehot(bus.req_done) || exp_done.size() == 0 || exp_done[0] != last_done_idx) begin
                    failures++;
                    $display("FAIL done: got req_done=%b, required index %0d", bus.req_done, (exp_done.size() == 0) ? -1 : exp_done[0]);
                end
                if (exp_done.size() != 0) void'(exp_done.pop_front());
            end
            if (bus.req_err != '0) begin
                checks++;
                err_count++;
                last_err_cyc = cyc;
                if (!$onehot(bus.req_err) || exp_err.size() == 0 || exp_err[0] != first_idx(bus.req_err)) begin
                    failures++;
                    $display("FAIL err: got req_err=%b, required index %0d", bus.req_err, (exp_err.size() == 0) ? -1 : exp_err[0]);
                end
                if (exp_err.size() != 0) void'(exp_err.pop_front());
            end
        end
    end

    // Synchronizer model: acks ack_dly cycles after each sync_en when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.sync_en && ack_dly > 0) begin
                repeat (ack_dly) @(posedge clk);
                #1 ack_auto = 1'b1;
                @(posedge clk);
                #1 ack_auto = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [NR-1:0] mask, input logic [NR*W-1:0] dv, input bit exp_g, input bit exp_d);
        xfer_t x;
        bus.req_data = dv;
        bus.req_en   = mask;
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                x.sel  = i;
                x.data = dv[i*W +: W];
                if (exp_g) exp_grant.push_back(x);
                if (exp_d) exp_done.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        bus.req_en = '0;
    endtask

    task automatic pulse_ack(output int a);
        ack_man = 1'b1;
        a = cyc;
        @(posedge clk);
        #1;
        ack_man = 1'b0;
    endtask

    task automatic wait_en(input int c0, input int bound, input string nm);
        int k = 0;
        while (en_count == c0 && k < bound) begin
            cycles(1);
            k++;
        end
        chk({nm, "_en_seen"}, 64'(en_count != c0), 64'd1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k = 0;
        while ((exp_grant.size() != 0 || exp_done.size() != 0 || bus.req_busy != '0) && k < bound) begin
            cycles(1);
            k++;
        end
        chk({nm, "_drained"}, 64'(exp_grant.size() + exp_done.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 64'(bus.req_busy), 64'd0);
        chk({nm, "_done"}, 64'(bus.req_done), 64'd0);
        chk({nm, "_err"},  64'(bus.req_err),  64'd0);
        chk({nm, "_en"},   64'(bus.sync_en),  64'd0);
        chk({nm, "_data"}, 64'(bus.sync_data), 64'd0);
        chk({nm, "_sel"},  64'(bus.sync_sel), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, a, c0, d0, e0, issued, k;
        logic [NR*W-1:0] dv;
        bus.req_en   = '0;
        bus.req_data = '0;

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        chk_zero("reset");

        // Single request, latency, done-cycle re-request dropped
        t  = cyc;
        c0 = en_count;
        drive(4'b0100, {16'h0, 16'hBEEF, 32'h0}, 1, 0);
        wait_en(c0, 10, "single");
        chk("single_en_latency", 64'(last_en_cyc - t), 64'd2);
        while (cyc < t + 10) cycles(1);
        chk("single_busy_wait", 64'(bus.req_busy), 64'b0100);
        exp_done.push_back(2);
        pulse_ack(a);
        @(negedge clk);
        chk("single_done_pulse", 64'(bus.req_done), 64'b0100);
        chk("single_busy_at_done", 64'(bus.req_busy), 64'd0);
        drive(4'b0100, {16'h0, 16'h5555, 32'h0}, 0, 0);
        cycles(6);
        chk("single_done_cycle", 64'(last_done_cyc - a), 64'd1);
        chk("single_rereq_dropped", 64'(bus.req_busy), 64'd0);

        // Contention after reset: 0,1,2,3 with ack+2 spacing
        do_reset();
        en_hist.delete();
        ack_dly = 3;
        drive(4'b1111, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1, 1);
        wait_idle(200, "contention");
        chk("contention_grants", 64'(en_hist.size()), 64'd4);
        for (int i = 1; i < 4 && i < en_hist.size(); i++)
            chk("contention_gap", 64'(en_hist[i] - en_hist[i-1]), 64'd5);

        // Fairness: 0 and 3 re-request after each done
        do_reset();
        ack_dly = 2;
        d0 = done_count;
        drive(4'b1001, {16'h3A00, 32'h0, 16'h0A00}, 1, 1);
        issued = 2;
        while (issued < 20) begin
            c0 = done_count;
            k  = 0;
            while (done_count == c0 && k < 50) begin
                cycles(1);
                k++;
            end
            if (done_count == c0) begin
                chk("fair_done_seen", 64'd0, 64'd1);
                break;
            end
            dv = '0;
            dv[last_done_idx*W +: W] = 16'h5000 + 16'(issued);
            drive(NR'(1) << last_done_idx, dv, 1, 1);
            issued++;
        end
        wait_idle(100, "fair");
        chk("fair_done_total", 64'(done_count - d0), 64'd20);
        ack_dly = 0;

        // Busy drop; ack during ISSUE ignored
        c0 = en_count;
        drive(4'b0010, {32'h0, 16'h1111, 16'h0}, 1, 0);
        drive(4'b0010, {32'h0, 16'h2222, 16'h0}, 0, 0);
        pulse_ack(a);
        cycles(4);
        chk("drop_still_busy", 64'(bus.req_busy), 64'b0010);
        wait_en(c0, 5, "drop");
        d0 = done_count;
        exp_done.push_back(1);
        pulse_ack(a);
        cycles(8);
        chk("drop_one_done", 64'(done_count - d0), 64'd1);
        chk("drop_busy_clear", 64'(bus.req_busy), 64'd0);

        // WAIT without ack
        c0 = en_count;
        drive(4'b0001, {48'h0, 16'h7777}, 1, 0);
        wait_en(c0, 10, "tmo");
`ifdef REG_SYNC_ARB_TIMEOUT_EN
        e0 = err_count;
        exp_err.push_back(0);
        k = 0;
        while (err_count == e0 && k < 40) begin
            cycles(1);
            k++;
        end
        chk("tmo_err_seen", 64'(err_count - e0), 64'd1);
        chk("tmo_err_cycle", 64'(last_err_cyc - last_en_cyc), 64'd9);
        cycles(2);
        chk("tmo_busy_clear", 64'(bus.req_busy), 64'd0);
`else
        e0 = err_count;
        cycles(1000);
        chk("wait_still_busy", 64'(bus.req_busy), 64'b0001);
        chk("wait_no_err", 64'(err_count - e0), 64'd0);
        exp_done.push_back(0);
        pulse_ack(a);
        cycles(3);
        chk("wait_busy_clear", 64'(bus.req_busy), 64'd0);
`endif

        // Reset during WAIT, stray ack afterwards
        c0 = en_count;
        drive(4'b1000, {16'h3333, 48'h0}, 1, 0);
        wait_en(c0, 10, "rstwait");
        cycles(2);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        pulse_ack(a);
        cycles(3);
        chk_zero("rstwait");
        ack_dly = 2;
        en_hist.delete();
        drive(4'b1001, {16'h3C3C, 32'h0, 16'h0C0C}, 1, 1);
        wait_idle(100, "rstwait_after");
        chk("rstwait_grants", 64'(en_hist.size()), 64'd2);
        ack_dly = 0;

        cycles(3);
        chk("sb_grant_empty", 64'(exp_grant.size()), 64'd0);
        chk("sb_err_empty", 64'(exp_err.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
